// File: rtl/i2s_mic_capture.sv
// Master-mode I2S receiver: generates bclk/ws and deserialises NUM_SD stereo mic lines into frames.
// Latency: a frame is presented on the bclk fall that ends slot 63, 64 BCLK (128*BCLK_DIV clk) per frame.
// Backpressure: one-deep output; a commit while an unaccepted frame is pending overwrites it and sets overrun.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                run enable; low halts the bit engine and discards the partial frame
//   clr_ovr           one-cycle pulse clearing the sticky overrun flag
//   sd[NUM_SD]        microphone serial data lines
//   bclk, ws          I2S bit clock and word select (0 = left slot, 1 = right slot)
//   left_data         left samples, line i at [i*DATA_W +: DATA_W]
//   right_data        right samples, same packing
//   sample_valid/_ready  frame handshake
//   overrun           sticky: a committed frame was overwritten before acceptance
module i2s_mic_capture #(
  parameter int BCLK_DIV = 5,
  parameter int DATA_W   = 24,
  parameter int NUM_SD   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr_ovr,
  input  logic [NUM_SD-1:0]        sd,
  output logic                     bclk,
  output logic                     ws,
  output logic [NUM_SD*DATA_W-1:0] left_data,
  output logic [NUM_SD*DATA_W-1:0] right_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     overrun
);

  localparam int              DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(BCLK_DIV - 1);
  // One-bit I2S delay: left MSB lands in slot 1, right MSB in slot 33.
  localparam logic [5:0]      LEFT_LO  = 6'd1;
  localparam logic [5:0]      LEFT_HI  = 6'(DATA_W);
  localparam logic [5:0]      RIGHT_LO = 6'd33;
  localparam logic [5:0]      RIGHT_HI = 6'(32 + DATA_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             ws_q, ws_d;
  logic [NUM_SD-1:0] sd_q, sd_d;
  logic [NUM_SD-1:0][DATA_W-1:0] left_sh_q, left_sh_d;
  logic [NUM_SD-1:0][DATA_W-1:0] right_sh_q, right_sh_d;
  logic [NUM_SD-1:0][DATA_W-1:0] left_data_q, left_data_d;
  logic [NUM_SD-1:0][DATA_W-1:0] right_data_q, right_data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic tc, rise_tick, fall_tick, commit, cap_left, cap_right;

  always_comb begin
    tc        = (div_cnt_q == DIV_TC);
    rise_tick = en && tc && !bclk_q;
    fall_tick = en && tc && bclk_q;
    commit    = fall_tick && (bit_cnt_q == 6'd63);
    cap_left  = rise_tick && (bit_cnt_q >= LEFT_LO) && (bit_cnt_q <= LEFT_HI);
    cap_right = rise_tick && (bit_cnt_q >= RIGHT_LO) && (bit_cnt_q <= RIGHT_HI);
  end

  // Bit engine: divider, bit counter, shift registers.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    ws_d       = ws_q;
    sd_d       = sd;
    left_sh_d  = left_sh_q;
    right_sh_d = right_sh_q;

    if (!en) begin
      div_cnt_d  = '0;
      bclk_d     = 1'b0;
      bit_cnt_d  = '0;
      ws_d       = 1'b0;
      left_sh_d  = '0;
      right_sh_d = '0;
    end else begin
      if (tc) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (fall_tick) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end
      // Taken from the next count so ws changes on the same clk as the bclk fall.
      ws_d = bit_cnt_d[5];
      for (int i = 0; i < NUM_SD; i++) begin
        if (cap_left) begin
          left_sh_d[i] = (left_sh_q[i] << 1) | DATA_W'(sd_q[i]);
        end
        if (cap_right) begin
          right_sh_d[i] = (right_sh_q[i] << 1) | DATA_W'(sd_q[i]);
        end
      end
      if (commit) begin
        left_sh_d  = '0;
        right_sh_d = '0;
      end
    end
  end

  // Output frame register and handshake; independent of en so a pending frame can still drain.
  always_comb begin
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (commit) begin
      left_data_d  = left_sh_q;
      right_data_d = right_sh_q;
      valid_d      = 1'b1;
    end
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    // Set after clear so a coincident set wins.
    if (commit && valid_q && !sample_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      ws_q         <= 1'b0;
      sd_q         <= '0;
      left_sh_q    <= '0;
      right_sh_q   <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      left_sh_q    <= left_sh_d;
      right_sh_q   <= right_sh_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bclk         = bclk_q;
  assign ws           = ws_q;
  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
module tb_i2s_mic_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clr_ovr, sample_ready;
  logic [3:0]  sd;
  logic        bclk, ws, sample_valid, overrun;
  logic [95:0] left_data, right_data;

  logic        en2;
  logic [0:0]  sd2;
  logic        bclk2, ws2, valid2, ovr2;
  logic [15:0] ldata2, rdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] lw [4];
  logic [31:0] rw [4];
  logic [31:0] lw2, rw2;

  i2s_mic_capture u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_ovr(clr_ovr), .sd(sd),
    .bclk(bclk), .ws(ws), .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
  );

  i2s_mic_capture #(.BCLK_DIV(2), .DATA_W(16), .NUM_SD(1)) u_sweep (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr_ovr(1'b0), .sd(sd2),
    .bclk(bclk2), .ws(ws2), .left_data(ldata2), .right_data(rdata2),
    .sample_valid(valid2), .sample_ready(1'b1), .overrun(ovr2)
  );

  // Microphone model: each slot's bit is put on the line after the bclk fall that opens it.
  // Unused slots carry 1s so any stray capture corrupts the word.
  function automatic logic mic_bit(input int s, input int dw, input logic [31:0] lw_i,
                                   input logic [31:0] rw_i);
    if (s >= 1 && s <= dw) return lw_i[dw - s];
    if (s >= 33 && s <= 32 + dw) return rw_i[dw + 32 - s];
    return 1'b1;
  endfunction

  int   slot, slot2;
  logic bprev, bprev2;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= 0;
      bprev  <= 1'b0;
      slot2  <= 0;
      bprev2 <= 1'b0;
    end else begin
      slot   <= !en  ? 0 : (bprev && !bclk)   ? (slot + 1) % 64  : slot;
      bprev  <= bclk;
      slot2  <= !en2 ? 0 : (bprev2 && !bclk2) ? (slot2 + 1) % 64 : slot2;
      bprev2 <= bclk2;
    end
  end

  always_comb begin
    sd = '0;
    for (int i = 0; i < 4; i++) sd[i] = mic_bit(slot, 24, lw[i], rw[i]);
    sd2[0] = mic_bit(slot2, 16, lw2, rw2);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [23:0] l0, input logic [23:0] r0,
                           input logic [23:0] l3, input logic [23:0] r3);
    lw[0] = {8'h0, l0}; rw[0] = {8'h0, r0};
    lw[1] = '0;         rw[1] = '0;
    lw[2] = '0;         rw[2] = '0;
    lw[3] = {8'h0, l3}; rw[3] = {8'h0, r3};
  endtask

  function automatic logic [95:0] exp_left();
    return {lw[3][23:0], lw[2][23:0], lw[1][23:0], lw[0][23:0]};
  endfunction

  function automatic logic [95:0] exp_right();
    return {rw[3][23:0], rw[2][23:0], rw[1][23:0], rw[0][23:0]};
  endfunction

  logic [95:0] held_l;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_ovr = 1'b0; sample_ready = 1'b0; en2 = 1'b0;
    lw2 = '0; rw2 = '0;
    set_words(24'hA5A5A5, 24'h5A5A5A, 24'h800001, 24'h7FFFFE);
    tick(3);
    check("rst_bclk", bclk, 1'b0);
    check("rst_ws", ws, 1'b0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_left", left_data, 96'h0);
    check("rst_right", right_data, 96'h0);

    rst_n = 1'b1;
    tick(2);
    // Edge numbering below counts clk edges after en rises.
    en = 1'b1; sample_ready = 1'b1;
    tick(4);   check("bclk_e4", bclk, 1'b0);
    tick(1);   check("bclk_rise_e5", bclk, 1'b1);
    tick(5);   check("bclk_fall_e10", bclk, 1'b0);
    tick(5);   check("bclk_rise_e15", bclk, 1'b1);
    tick(304); check("ws_e319", ws, 1'b0);
    check("bclk_e319", bclk, 1'b1);
    tick(1);   check("ws_e320", ws, 1'b1);
    check("bclk_e320", bclk, 1'b0);
    tick(319); check("valid_e639", sample_valid, 1'b0);
    tick(1);   check("valid_e640", sample_valid, 1'b1);
    check("l0_a5", left_data[23:0], 24'hA5A5A5);
    check("r3_7ffffe", right_data[95:72], 24'h7FFFFE);
    check("left_f1", left_data, 96'h800001_000000_000000_A5A5A5);
    check("right_f1", right_data, 96'h7FFFFE_000000_000000_5A5A5A);
    tick(1);   check("valid_e641", sample_valid, 1'b0);

    // Backpressure across two commits.
    sample_ready = 1'b0;
    set_words(24'h123456, 24'h654321, 24'hC0FFEE, 24'h0F0F0F);
    tick(639); check("bp_valid_c2", sample_valid, 1'b1);
    check("bp_ovr_c2", overrun, 1'b0);
    check("bp_left_c2", left_data, 96'hC0FFEE_000000_000000_123456);
    check("bp_right_c2", right_data, exp_right());
    held_l = exp_left();
    tick(1);   check("bp_valid_hold", sample_valid, 1'b1);
    set_words(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    tick(638); check("bp_stable", left_data, held_l);
    check("bp_ovr_pre", overrun, 1'b0);
    tick(1);   check("bp_valid_c3", sample_valid, 1'b1);
    check("bp_ovr_c3", overrun, 1'b1);
    check("bp_left_c3", left_data, 96'h333333_000000_000000_111111);
    check("bp_right_c3", right_data, 96'h444444_000000_000000_222222);
    tick(1);
    clr_ovr = 1'b1;
    set_words(24'hABCDEF, 24'hFEDCBA, 24'h000001, 24'h800000);
    tick(1);   clr_ovr = 1'b0;
    check("clr_ovr", overrun, 1'b0);
    check("clr_valid", sample_valid, 1'b1);
    tick(637); sample_ready = 1'b1;
    tick(1);   check("coinc_valid", sample_valid, 1'b1);
    check("coinc_ovr", overrun, 1'b0);
    check("coinc_left", left_data, 96'h000001_000000_000000_ABCDEF);
    tick(1);   check("coinc_drain", sample_valid, 1'b0);

    // Abort mid-frame during slot 20 (bclk high phase).
    held_l = left_data;
    tick(204); check("abort_bclk_pre", bclk, 1'b1);
    en = 1'b0;
    tick(1);   check("abort_bclk", bclk, 1'b0);
    check("abort_ws", ws, 1'b0);
    tick(59);  check("abort_no_commit", sample_valid, 1'b0);
    check("abort_bclk_idle", bclk, 1'b0);
    check("abort_left_held", left_data, held_l);
    set_words(24'h5A5A5A, 24'hA5A5A5, 24'h7FFFFE, 24'h800001);
    en = 1'b1;
    tick(639); check("reen_valid_e639", sample_valid, 1'b0);
    check("reen_left_held", left_data, held_l);
    sample_ready = 1'b0;
    tick(1);   check("reen_valid_e640", sample_valid, 1'b1);
    check("reen_left", left_data, 96'h7FFFFE_000000_000000_5A5A5A);
    check("reen_right", right_data, 96'h800001_000000_000000_A5A5A5);

    // Asynchronous reset mid-frame with a pending frame.
    tick(100); check("pre_rst_valid", sample_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", sample_valid, 1'b0);
    check("arst_left", left_data, 96'h0);
    check("arst_right", right_data, 96'h0);
    check("arst_bclk", bclk, 1'b0);
    check("arst_ws", ws, 1'b0);
    check("arst_ovr", overrun, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; sample_ready = 1'b1;
    set_words(24'hDEADBE, 24'hEFCAFE, 24'h012345, 24'h6789AB);
    tick(639); check("post_rst_e639", sample_valid, 1'b0);
    tick(1);   check("post_rst_valid", sample_valid, 1'b1);
    check("post_rst_left", left_data, 96'h012345_000000_000000_DEADBE);
    check("post_rst_right", right_data, 96'h6789AB_000000_000000_EFCAFE);

    // Parameter sweep instance: BCLK_DIV=2, DATA_W=16, NUM_SD=1.
    lw2 = 32'h0000BEEF; rw2 = 32'h00001234;
    en2 = 1'b1;
    tick(2);   check("sw_bclk_rise", bclk2, 1'b1);
    tick(2);   check("sw_bclk_fall", bclk2, 1'b0);
    tick(123); check("sw_ws_e127", ws2, 1'b0);
    tick(1);   check("sw_ws_e128", ws2, 1'b1);
    tick(127); check("sw_valid_e255", valid2, 1'b0);
    tick(1);   check("sw_valid_e256", valid2, 1'b1);
    check("sw_left", ldata2, 16'hBEEF);
    check("sw_right", rdata2, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_mic_capture.md
Name: i2s_mic_capture

Overview:
- Master-mode I2S receiver for the MEMS microphone array, clocked from the 30 MHz PLL output (27 MHz × 10/9).
- Generates BCLK and WS for all microphones and deserialises NUM_SD data lines. Each line carries a left/right microphone pair.
- Presents one frame of 2×NUM_SD samples per WS period through a valid/ready handshake to the downstream beamforming/buffer stage.

Parameters:
- BCLK_DIV, 5, system clocks per BCLK half-period; BCLK = 30 MHz / (2·BCLK_DIV) = 3 MHz.
- DATA_W, 24, captured bits per slot, MSB first; range 1..31.
- NUM_SD, 4, number of serial data lines (2 mics each).

Ports:
- clk  in  1  system clock from PLL CLKOUT, 30 MHz.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low halts and resets the bit engine.
- clr_ovr  in  1  one-cycle pulse, clears the overrun flag.
- sd  in  NUM_SD  microphone serial data lines.
- bclk  out  1  I2S bit clock to microphones.
- ws  out  1  I2S word select: 0 = left slot, 1 = right slot.
- left_data  out  NUM_SD*DATA_W  left samples; line i occupies bits [i*DATA_W +: DATA_W].
- right_data  out  NUM_SD*DATA_W  right samples, same packing.
- sample_valid  out  1  frame available.
- sample_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: a committed frame was overwritten before acceptance.

Behaviour:
- Reset values: bclk, ws, sample_valid, overrun all 0; left_data and right_data all 0; divider, bit_cnt and shift registers all 0.
- Divider:
  - While en=1, div_cnt counts 0..BCLK_DIV-1. At terminal count bclk toggles and div_cnt wraps to 0.
  - bclk 0→1 is the rise tick; bclk 1→0 is the fall tick.
- Bit counter: 6-bit bit_cnt increments on each fall tick, wrapping 63→0. ws is a register that follows bit_cnt[5]. One frame = 64 BCLK = 128·BCLK_DIV clk (640 at defaults).
- Start: on en rising, bclk=0 and bit_cnt=0. Slot 0 spans the first BCLK period.
- Input path: sd is registered once per clk (sd_q). Capture uses sd_q at the rise tick.
- Slot mapping (standard I2S, one-bit delay):
  - Left bit k (k=0 is MSB) is sampled in slot bit_cnt = 1+k, for k < DATA_W.
  - Right bit k is sampled in slot 33+k.
  - All other slots are ignored.
  - Each line shifts left into its own left or right shift register.
- Commit: on the fall tick where bit_cnt==63:
  - shift registers are copied into left_data/right_data;
  - sample_valid is set in the same cycle the registers update;
  - shift registers are cleared.
- First commit occurs 640 clk after en rises (defaults).
- Handshake:
  - Transfer occurs when sample_valid && sample_ready; sample_valid then clears next cycle.
  - Data is stable while sample_valid=1 and no commit occurs.
  - Commit while sample_valid=1 and sample_ready=0: data is overwritten, sample_valid stays 1, overrun←1.
  - Commit in the same cycle as a transfer: the old frame is consumed, the new frame is loaded, sample_valid stays 1, no overrun.
- overrun: sticky; cleared by clr_ovr. If a set and a clear land in the same cycle, set wins.
- en low mid-frame:
  - the next clk forces bclk=0, ws=0, div_cnt=0, bit_cnt=0 and clears the shift registers;
  - the partial frame is discarded;
  - sample_valid, left_data/right_data and overrun hold, and the handshake still completes.
- Async reset mid-frame: all state returns immediately to reset values.

Test Plan:
- Clock generation: reset, en=1, defaults → bclk period 10 clk with 50% duty; ws toggles every 320 clk; ws=1 first appears 320 clk after en, at the same cycle as bclk falls.
- Data capture: model drives line0 left=0xA5A5A5, right=0x5A5A5A, line3 left=0x800001, right=0x7FFFFE, lines 1/2 = 0, per I2S on bclk fall; sample_ready=1 → sample_valid pulses 1 cycle at clk 640; left_data[23:0]=0xA5A5A5, right_data[95:72]=0x7FFFFE; bits driven in slots 0, 25..32 and 57..63 do not affect data.
- Backpressure: sample_ready=0 for 2 frames → sample_valid stays 1; overrun=1 after the second commit; data equals frame 2. clr_ovr pulse → overrun=0. Ready coincident with the third commit → no overrun.
- Enable abort: deassert en at bit_cnt=20 → bclk and ws are 0 on the next clk with no commit; re-enable → next frame is captured correctly 640 clk later; held data unchanged meanwhile.
- Parameter sweep: BCLK_DIV=2, DATA_W=16, NUM_SD=1 → bclk period 4 clk, frame 256 clk, 16-bit words captured MSB-first.
- Reset: assert rst_n low mid-frame with sample_valid=1 → all outputs 0 asynchronously; normal operation resumes after release.
